avalon_pio_ctrl: RTL and testbench

Parametrised Avalon-MM parallel I/O slave for the Nios system. It replaces the single fixed 32-bit output-only data register with per-bit direction control, atomic set/clear writes, synchronised inputs, edge capture and a maskable interrupt. It sits on the Nios data master as a zero-wait-state slave and drives and samples board-level pins such as LEDs, switches and keys.

---
 rtl/avalon_pio_ctrl_pkg.sv | 18 +
 rtl/pio_edge_sync.sv | 40 ++++
 rtl/avalon_pio_ctrl.sv | 99 +++++++++
 tb/tb_avalon_pio_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/avalon_pio_ctrl_pkg.sv
// Shared constants for the Avalon-MM PIO slave: register map, edge and irq source encodings.
package avalon_pio_ctrl_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_DIRECTION = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR    = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam int IRQ_LEVEL = 0;
  localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_edge_sync.sv
// Multi-flop synchroniser on the pin vector plus a one-cycle edge strobe per bit.
// in_sync lags in_port by SYNC_STAGES cycles; edge_stb is combinational from in_sync/in_prev.
module pio_edge_sync
  import avalon_pio_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_stb
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] in_prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      in_prev <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      in_prev <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_sync = sync_q[SYNC_STAGES-1];
  assign rise    = in_sync & ~in_prev;
  assign fall    = ~in_sync & in_prev;

  assign edge_stb = (EDGE_TYPE == EDGE_FALL) ? fall :
                    (EDGE_TYPE == EDGE_ANY)  ? (rise | fall) : rise;

endmodule

// File: rtl/avalon_pio_ctrl.sv
// Zero-wait-state Avalon-MM PIO: direction, atomic set/clear, edge capture and maskable irq.
module avalon_pio_ctrl
  import avalon_pio_ctrl_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          EDGE_TYPE   = EDGE_RISE,
  parameter int          IRQ_TYPE    = IRQ_EDGE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_stb;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] rd;
  logic             wr;
  logic             irq_next;

  pio_edge_sync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_edge_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .in_sync  (in_sync),
    .edge_stb (edge_stb)
  );

  assign wr      = chipselect & ~write_n;
  assign wdata   = writedata[WIDTH-1:0];
  assign cap_clr = (wr && address == ADDR_EDGECAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= RESET_VALUE[WIDTH-1:0];
      direction <= DIR_RESET[WIDTH-1:0];
      mask      <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:      data_out  <= wdata;
        ADDR_DIRECTION: direction <= wdata;
        ADDR_IRQMASK:   mask      <= wdata;
        ADDR_OUTSET:    data_out  <= data_out | wdata;
        ADDR_OUTCLR:    data_out  <= data_out & ~wdata;
        default:        ;
      endcase
    end
  end

  // A fresh edge outranks a simultaneous write-1-clear so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecap <= '0;
      irq     <= 1'b0;
    end else begin
      edgecap <= (edgecap & ~cap_clr) | edge_stb;
      irq     <= irq_next;
    end
  end

  assign irq_next = (IRQ_TYPE == IRQ_LEVEL) ? |(in_sync & mask) : |(edgecap & mask);

  always_comb begin
    rd = '0;
    case (address)
      ADDR_DATA:      rd = (direction & data_out) | (~direction & in_sync);
      ADDR_DIRECTION: rd = direction;
      ADDR_IRQMASK:   rd = mask;
      ADDR_EDGECAP:   rd = edgecap;
      default:        rd = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd;
  end

  assign out_port = data_out;
  assign oe       = direction;

endmodule

// File: tb/tb_avalon_pio_ctrl.sv
// Directed bench: edge-irq instance (RESET_VALUE A5), level-irq instance, and an 8-bit instance.
module tb_avalon_pio_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic        cs_a = 1'b0, cs_l = 1'b0, cs_w = 1'b0;

  logic [31:0] in_a = 32'h0, in_l = 32'h0;
  logic [7:0]  in_w = 8'h0;
  logic [31:0] rd_a, rd_l, rd_w;
  logic [31:0] out_a, oe_a, out_l, oe_l;
  logic [7:0]  out_w, oe_w;
  logic        irq_a, irq_l, irq_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  avalon_pio_ctrl #(.WIDTH(32), .RESET_VALUE(32'h0000_00A5), .DIR_RESET(32'h0),
                    .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .out_port(out_a), .oe(oe_a), .irq(irq_a));

  avalon_pio_ctrl #(.WIDTH(32), .RESET_VALUE(32'h0), .DIR_RESET(32'h0),
                    .EDGE_TYPE(0), .IRQ_TYPE(0), .SYNC_STAGES(2)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_l),
    .write_n(write_n), .writedata(writedata), .readdata(rd_l),
    .in_port(in_l), .out_port(out_l), .oe(oe_l), .irq(irq_l));

  avalon_pio_ctrl #(.WIDTH(8), .RESET_VALUE(32'h0), .DIR_RESET(32'h0),
                    .EDGE_TYPE(0), .IRQ_TYPE(1), .SYNC_STAGES(2)) u_w8 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_w),
    .write_n(write_n), .writedata(writedata), .readdata(rd_w),
    .in_port(in_w), .out_port(out_w), .oe(oe_w), .irq(irq_w));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus write sampled on the posedge between two negedges; returns on the later negedge.
  task automatic bus_wr(input int tgt, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0;
    cs_a = (tgt == 0); cs_l = (tgt == 1); cs_w = (tgt == 2);
    @(negedge clk);
    write_n = 1'b1; cs_a = 1'b0; cs_l = 1'b0; cs_w = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic rd_sel(input logic [2:0] a);
    address = a;
    #1;
  endtask

  initial begin
    // Asynchronous reset before any clock edge
    #1 reset_n = 1'b0;
    #1;
    check("rst_out", out_a, 32'h0000_00A5);
    check("rst_oe", oe_a, 32'h0);
    check("rst_irq", 32'(irq_a), 32'h0);
    wait_neg(2);
    reset_n = 1'b1;
    wait_neg(1);
    rd_sel(3'd0); check("rst_rd_data", rd_a, 32'h0);
    rd_sel(3'd1); check("rst_rd_dir", rd_a, 32'h0);
    rd_sel(3'd2); check("rst_rd_mask", rd_a, 32'h0);
    rd_sel(3'd3); check("rst_rd_cap", rd_a, 32'h0);
    rd_sel(3'd4); check("rst_rd_set", rd_a, 32'h0);
    rd_sel(3'd6); check("rst_rd_6", rd_a, 32'h0);

    // Direction plus atomic set/clear
    bus_wr(0, 3'd1, 32'h0000_00FF);
    check("dir_oe", oe_a, 32'h0000_00FF);
    check("dir_out_keep", out_a, 32'h0000_00A5);
    bus_wr(0, 3'd0, 32'h0000_003C);
    check("data_out", out_a, 32'h0000_003C);
    bus_wr(0, 3'd4, 32'h0000_0041);
    check("outset", out_a, 32'h0000_007D);
    bus_wr(0, 3'd5, 32'h0000_0004);
    check("outclr", out_a, 32'h0000_0079);
    bus_wr(0, 3'd7, 32'hFFFF_FFFF);
    check("addr7_ignored", out_a, 32'h0000_0079);
    in_a = 32'hDEAD_BEEF;
    wait_neg(4);
    rd_sel(3'd0); check("rd_data_mix", rd_a, 32'hDEAD_BE79);
    rd_sel(3'd5); check("rd_outclr_0", rd_a, 32'h0);
    rd_sel(3'd3); check("cap_rise_all", rd_a, 32'hDEAD_BEEF);
    check("irq_masked", 32'(irq_a), 32'h0);
    in_a = 32'h0;
    wait_neg(4);
    rd_sel(3'd3); check("cap_no_fall", rd_a, 32'hDEAD_BEEF);
    bus_wr(0, 3'd3, 32'hFFFF_FFFF);
    rd_sel(3'd3); check("cap_clr_all", rd_a, 32'h0);

    // Edge capture timing with mask bit 0
    bus_wr(0, 3'd2, 32'h0000_0001);
    rd_sel(3'd2); check("mask_rd", rd_a, 32'h1);
    address = 3'd3;
    in_a = 32'h1;
    wait_neg(1); check("edge_t1", rd_a, 32'h0);
    wait_neg(1); check("edge_t2", rd_a, 32'h0);
    wait_neg(1); check("edge_t3_cap", rd_a, 32'h1);
    check("edge_t3_irq", 32'(irq_a), 32'h0);
    wait_neg(1); check("edge_t4_irq", 32'(irq_a), 32'h1);
    bus_wr(0, 3'd3, 32'h1);
    check("w1c_cap", rd_a, 32'h0);
    check("w1c_irq_hold", 32'(irq_a), 32'h1);
    wait_neg(1); check("w1c_irq_low", 32'(irq_a), 32'h0);

    // Clear colliding with a new edge: set wins
    in_a = 32'h0;
    wait_neg(4);
    in_a = 32'h1;
    wait_neg(1);
    bus_wr(0, 3'd3, 32'h1);
    check("coll_cap", rd_a, 32'h1);
    wait_neg(1);
    check("coll_irq", 32'(irq_a), 32'h1);
    check("coll_cap2", rd_a, 32'h1);
    wait_neg(1);
    check("coll_irq2", 32'(irq_a), 32'h1);

    // Level irq on bit 1 only
    bus_wr(1, 3'd2, 32'h0000_0002);
    in_l = 32'h1;
    wait_neg(5); check("lvl_bit0_ignored", 32'(irq_l), 32'h0);
    in_l = 32'h3;
    wait_neg(2); check("lvl_rise_t2", 32'(irq_l), 32'h0);
    wait_neg(1); check("lvl_rise_t3", 32'(irq_l), 32'h1);
    in_l = 32'h0;
    wait_neg(2); check("lvl_fall_t2", 32'(irq_l), 32'h1);
    wait_neg(1); check("lvl_fall_t3", 32'(irq_l), 32'h0);

    // 8-bit instance and mid-write asynchronous reset
    bus_wr(2, 3'd0, 32'hFFFF_FFFF);
    bus_wr(2, 3'd1, 32'hFFFF_FFFF);
    check("w8_out", 32'(out_w), 32'h0000_00FF);
    check("w8_oe", 32'(oe_w), 32'h0000_00FF);
    rd_sel(3'd0); check("w8_rd_data", rd_w, 32'h0000_00FF);
    rd_sel(3'd1); check("w8_rd_dir", rd_w, 32'h0000_00FF);
    @(negedge clk);
    address = 3'd5; writedata = 32'h0000_000F; write_n = 1'b0; cs_w = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_w8_out", 32'(out_w), 32'h0);
    check("mid_rst_w8_oe", 32'(oe_w), 32'h0);
    check("mid_rst_a_out", out_a, 32'h0000_00A5);
    check("mid_rst_a_oe", oe_a, 32'h0);
    check("mid_rst_a_irq", 32'(irq_a), 32'h0);
    @(negedge clk);
    write_n = 1'b1; cs_w = 1'b0;
    reset_n = 1'b1;
    wait_neg(1);
    rd_sel(3'd3); check("post_rst_cap", rd_a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
